// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution feature-map path.
package conv_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned KERNEL_SIZE = 5;
  localparam int unsigned IMAGE_SIZE  = 28;
  localparam int unsigned OUT_SIZE    = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned DEPTH       = OUT_SIZE * OUT_SIZE;

  typedef enum logic {
    COLLECT = 1'b0,
    READOUT = 1'b1
  } fmap_state_e;

endpackage

// File: rtl/fmap_ram.sv
// Feature-map storage: one synchronous write port, one registered read port.
// The array itself is never reset; only the read register is.
module fmap_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 576,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port: store the word when requested.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: capture on request, otherwise hold the last word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fmap_collector.sv
// Collects one OUT_SIZE x OUT_SIZE feature map from the convolver, then
// serves it back row-major to a downstream reader before accepting the next.
module fmap_collector
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = conv_pkg::DATA_WIDTH,
  parameter int unsigned KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
  parameter int unsigned IMAGE_SIZE  = conv_pkg::IMAGE_SIZE
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              enable,
  input  logic [DATA_WIDTH-1:0]                             data_in,
  input  logic                                              rd_en,
  output logic [DATA_WIDTH-1:0]                             rd_data,
  output logic                                              rd_valid,
  output logic                                              frame_done,
  output logic [$clog2(IMAGE_SIZE-KERNEL_SIZE+1)-1:0]       wr_row,
  output logic [$clog2(IMAGE_SIZE-KERNEL_SIZE+1)-1:0]       wr_col,
  output logic                                              overflow
);

  localparam int unsigned OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned DEPTH    = OUT_SIZE * OUT_SIZE;
  localparam int unsigned CW       = $clog2(OUT_SIZE);
  localparam int unsigned AW       = $clog2(DEPTH);

  fmap_state_e   state_q;
  logic [CW-1:0] wr_row_q;
  logic [CW-1:0] wr_col_q;
  logic [AW-1:0] rd_ptr_q;
  logic          rd_valid_q;
  logic          frame_done_q;
  logic          overflow_q;

  logic          wr_fire;
  logic          rd_fire;
  logic          row_last;
  logic          col_last;
  logic          rd_last;
  logic [AW-1:0] waddr;

  // Qualify requests against the current state and form the write address.
  always_comb begin
    wr_fire  = (state_q == COLLECT) && enable;
    rd_fire  = (state_q == READOUT) && rd_en;
    row_last = (wr_row_q == CW'(OUT_SIZE - 1));
    col_last = (wr_col_q == CW'(OUT_SIZE - 1));
    rd_last  = (rd_ptr_q == AW'(DEPTH - 1));
    waddr    = AW'(wr_row_q) * AW'(OUT_SIZE) + AW'(wr_col_q);
  end

  // Collect/readout FSM with pointers and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= COLLECT;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      rd_ptr_q     <= '0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      case (state_q)
        COLLECT: begin
          if (enable) begin
            if (col_last) begin
              wr_col_q <= '0;
              if (row_last) begin
                wr_row_q     <= '0;
                state_q      <= READOUT;
                frame_done_q <= 1'b1;
              end else begin
                wr_row_q <= wr_row_q + 1'b1;
              end
            end else begin
              wr_col_q <= wr_col_q + 1'b1;
            end
          end
        end
        READOUT: begin
          // Any pixel arriving while the frame is held, including on the
          // final read, is dropped and flagged.
          if (enable) begin
            overflow_q <= 1'b1;
          end
          if (rd_en) begin
            if (rd_last) begin
              rd_ptr_q     <= '0;
              state_q      <= COLLECT;
              frame_done_q <= 1'b0;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  fmap_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (wr_fire),
    .waddr_i (waddr),
    .wdata_i (data_in),
    .re_i    (rd_fire),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign rd_valid   = rd_valid_q;
  assign frame_done = frame_done_q;
  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fmap_collector.sv
// Scoreboard bench for fmap_collector: stimulus drives on the falling edge and
// pushes predictions from a frame-level model; a monitor checks after each
// rising edge.
module tb_fmap_collector;

  localparam int DW  = 16;
  localparam int OS  = 24;
  localparam int DEP = OS * OS;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          frame_done;
  logic [4:0]    wr_row;
  logic [4:0]    wr_col;
  logic          overflow;

  always #5 clk = ~clk;

  fmap_collector #(
    .DATA_WIDTH  (16),
    .KERNEL_SIZE (5),
    .IMAGE_SIZE  (28)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .frame_done (frame_done),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .overflow   (overflow)
  );

  typedef struct {
    bit          fd;
    bit          ovf;
    int          row;
    int          col;
    bit          rv;
    logic [DW-1:0] rdata;
  } status_t;

  typedef struct {
    logic [DW-1:0] data;
    int            stamp;
  } rd_t;

  status_t sq[$];
  rd_t     rq[$];
  int      n_cmp = 0;
  int      n_bad = 0;
  int      cyc   = 0;
  bit      mon_en = 1'b0;

  // Frame-level reference model.
  logic [DW-1:0] m_mem [DEP];
  int            m_cnt  = 0;
  int            m_rptr = 0;
  bit            m_ro   = 1'b0;
  bit            m_ovf  = 1'b0;
  logic [DW-1:0] m_last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_status(input bit rv);
    status_t s;
    s.fd    = m_ro;
    s.ovf   = m_ovf;
    s.row   = m_cnt / OS;
    s.col   = m_cnt % OS;
    s.rv    = rv;
    s.rdata = m_last;
    sq.push_back(s);
  endtask

  // Called at a falling edge: drive one cycle, predict, wait for next falling edge.
  task automatic cycle(input bit en, input logic [DW-1:0] d, input bit re);
    rd_t r;
    bit  rv;
    rv      = 1'b0;
    enable  = en;
    data_in = d;
    rd_en   = re;
    if (!m_ro) begin
      if (en) begin
        m_mem[m_cnt] = d;
        m_cnt++;
        if (m_cnt == DEP) begin
          m_cnt = 0;
          m_ro  = 1'b1;
        end
      end
    end else begin
      if (en) m_ovf = 1'b1;
      if (re) begin
        r.data  = m_mem[m_rptr];
        r.stamp = cyc + 1;
        rq.push_back(r);
        m_last = m_mem[m_rptr];
        rv     = 1'b1;
        m_rptr++;
        if (m_rptr == DEP) begin
          m_rptr = 0;
          m_ro   = 1'b0;
        end
      end
    end
    push_status(rv);
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || frame_done !== 1'b0 ||
        overflow !== 1'b0 || wr_row !== '0 || wr_col !== '0) begin
      n_bad++;
      $display("FAIL %s: got rd_data=%h rd_valid=%b fd=%b ovf=%b row=%0d col=%0d, want all zero",
               name, rd_data, rd_valid, frame_done, overflow, wr_row, wr_col);
    end
  endtask

  // Called at a falling edge: assert reset mid-phase, check, release at next falling edge.
  task automatic do_reset();
    enable = 1'b0;
    rd_en  = 1'b0;
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    m_cnt  = 0;
    m_rptr = 0;
    m_ro   = 1'b0;
    m_ovf  = 1'b0;
    m_last = '0;
    push_status(1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare status every cycle and read data whenever rd_valid is seen.
  initial begin
    status_t s;
    rd_t     r;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        n_cmp++;
        if (sq.size() == 0) begin
          n_bad++;
          $display("FAIL status_underflow: cycle %0d has no prediction", cyc);
        end else begin
          s = sq.pop_front();
          if (frame_done !== s.fd || overflow !== s.ovf || int'(wr_row) != s.row ||
              int'(wr_col) != s.col || rd_valid !== s.rv ||
              (!s.rv && rd_data !== s.rdata)) begin
            n_bad++;
            $display("FAIL status cyc=%0d: got fd=%b ovf=%b row=%0d col=%0d rv=%b rd=%h, want fd=%b ovf=%b row=%0d col=%0d rv=%b rd=%h",
                     cyc, frame_done, overflow, wr_row, wr_col, rd_valid, rd_data,
                     s.fd, s.ovf, s.row, s.col, s.rv, s.rdata);
          end
        end
        if (rd_valid === 1'b1) begin
          n_cmp++;
          if (rq.size() == 0) begin
            n_bad++;
            $display("FAIL rd_spurious cyc=%0d: got rd_valid=1 rd=%h, want no read", cyc, rd_data);
          end else begin
            r = rq.pop_front();
            if (rd_data !== r.data || cyc != r.stamp) begin
              n_bad++;
              $display("FAIL rd_data cyc=%0d: got %h at cycle %0d, want %h at cycle %0d",
                       cyc, rd_data, cyc, r.data, r.stamp);
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    reset   = 1'b1;
    enable  = 1'b0;
    data_in = '0;
    rd_en   = 1'b0;
    #9 check_zero("reset_state");
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Full frame of index data, then a clean readout with a pixel on the final read.
    for (int i = 0; i < DEP; i++) cycle(1'b1, 16'(i), 1'b0);
    while (m_ro) cycle(m_rptr == DEP - 1, 16'h7FFF, 1'b1);
    cycle(1'b0, '0, 1'b0);

    do_reset();

    // Gapped writes of negative values with reads requested during collection.
    k = 0;
    while (!m_ro) begin
      cycle(1'b1, 16'(-(k + 1)), 1'b1);
      k++;
      if (!m_ro) cycle(1'b0, 16'($urandom), 1'b1);
    end
    // Random reads with overflow pixels mixed in.
    while (m_ro) cycle($urandom_range(0, 3) == 0, 16'h7FFF, 1'($urandom_range(0, 1)));
    cycle(1'b0, '0, 1'b0);

    // Partial frame discarded by reset.
    for (int i = 0; i < 100; i++) cycle(1'b1, 16'($urandom), 1'b0);
    do_reset();

    // Random traffic over a whole frame and its readback.
    while (!m_ro) cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    while (m_ro) cycle(1'b0, 16'($urandom), 1'($urandom_range(0, 1)));
    repeat (3) cycle(1'b0, '0, 1'b0);

    n_cmp++;
    if (rq.size() != 0 || sq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d reads and %0d status entries outstanding, want 0 and 0",
               rq.size(), sq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
